// File: rtl/yabot_stream_pkg.sv
// Shared stream helpers: byte width, packer state encoding, keep-mask builder.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package yabot_stream_pkg;

  localparam int BYTE_W  = 8;
  localparam int MAX_BPW = 64;

  // Packer state: either accumulating bytes or holding a closed word in acc.
  typedef enum logic {
    IDLE_ACC = 1'b0,
    PENDING  = 1'b1
  } pack_state_e;

  // n ones starting at bit 0; callers cast down to their own lane count.
  function automatic logic [MAX_BPW-1:0] keep_mask(input int n);
    logic [MAX_BPW-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_BPW; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Output word register with valid/ready handshake and load/hold control.
// Latency: load at edge N shows m_valid high after edge N.
// Backpressure: contents held stable while m_valid && !m_ready; out_free is purely registered-state + m_ready.
module stream_out_reg #(
  parameter int WIDTH = 32,
  parameter int BPW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] ld_data,
  input  logic [BPW-1:0]   ld_keep,
  input  logic             ld_last,
  output logic [WIDTH-1:0] m_data,
  output logic [BPW-1:0]   m_keep,
  output logic             m_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             out_free,
  output logic             fire
);

  assign out_free = !m_valid || m_ready;
  assign fire     = m_valid && m_ready;

  // Load a new word when asked (caller guarantees out_free), else drop valid after handoff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data  <= '0;
      m_keep  <= '0;
      m_last  <= 1'b0;
      m_valid <= 1'b0;
    end else if (load) begin
      m_data  <= ld_data;
      m_keep  <= ld_keep;
      m_last  <= ld_last;
      m_valid <= 1'b1;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/byte_word_packer.sv
// Packs a little-endian byte stream into WIDTH-bit words; s_last or flush closes a partial word.
// Latency: closing byte accepted at edge N gives m_valid after edge N; 1 byte/cycle sustained.
// Backpressure: one closed word can wait in acc (pending); s_ready drops only while pending, registered.
module byte_word_packer
  import yabot_stream_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int CNT_W = 16,
  localparam int BPW   = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] m_data,
  output logic [BPW-1:0]   m_keep,
  output logic             m_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int             IDX_W   = $clog2(BPW);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(BPW - 1);

  pack_state_e      state, state_nxt;
  logic [WIDTH-1:0] acc, acc_wr;
  logic [IDX_W-1:0] idx;
  logic [BPW-1:0]   pend_keep, close_keep;
  logic             pend_last;
  logic             pending, accept, close, out_free, fire;
  logic             out_load;
  logic [WIDTH-1:0] ld_data;
  logic [BPW-1:0]   ld_keep;
  logic             ld_last;

  assign pending = (state == PENDING);
  assign s_ready = !pending;
  assign accept  = s_valid && s_ready;

  // Word closes on a full word, a packet end, or a flush that has bytes to close.
  assign close = (accept && ((idx == IDX_MAX) || s_last || flush)) ||
                 (!accept && flush && !pending && (idx != '0));

  // Accumulator image including this cycle's byte, and the keep mask of the closing word.
  always_comb begin
    acc_wr = acc;
    if (accept) acc_wr[int'(idx)*BYTE_W +: BYTE_W] = s_data;
    close_keep = BPW'(keep_mask(int'(idx) + (accept ? 1 : 0)));
  end

  // Next state and output-register load selection (drain pending first, else direct close).
  always_comb begin
    state_nxt = state;
    out_load  = 1'b0;
    ld_data   = acc_wr;
    ld_keep   = close_keep;
    ld_last   = accept && s_last;
    case (state)
      IDLE_ACC: begin
        if (close) begin
          if (out_free) out_load  = 1'b1;
          else          state_nxt = PENDING;
        end
      end
      PENDING: begin
        ld_data = acc;
        ld_keep = pend_keep;
        ld_last = pend_last;
        if (out_free) begin
          out_load  = 1'b1;
          state_nxt = IDLE_ACC;
        end
      end
      default: state_nxt = IDLE_ACC;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE_ACC;
    else        state <= state_nxt;
  end

  // Accumulator, byte index and frozen pending-word attributes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      idx       <= '0;
      pend_keep <= '0;
      pend_last <= 1'b0;
    end else if (pending) begin
      if (out_free) begin
        acc       <= '0;
        pend_keep <= '0;
        pend_last <= 1'b0;
      end
    end else if (close) begin
      idx <= '0;
      if (out_free) begin
        acc <= '0;
      end else begin
        acc       <= acc_wr;
        pend_keep <= close_keep;
        pend_last <= accept && s_last;
      end
    end else if (accept) begin
      acc <= acc_wr;
      idx <= idx + 1'b1;
    end
  end

  // Handed-off word counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    word_cnt <= '0;
    else if (fire) word_cnt <= word_cnt + 1'b1;
  end

  stream_out_reg #(
    .WIDTH (WIDTH),
    .BPW   (BPW)
  ) u_out (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (out_load),
    .ld_data  (ld_data),
    .ld_keep  (ld_keep),
    .ld_last  (ld_last),
    .m_data   (m_data),
    .m_keep   (m_keep),
    .m_last   (m_last),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .out_free (out_free),
    .fire     (fire)
  );

endmodule
